// File: rtl/fetch_unit_if.sv
// Instruction memory read bus between the fetch stage (master) and instruction memory (slave).
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (output mem_addr, mem_ren, input mem_rdata, mem_ready);
    modport slave  (input mem_addr, mem_ren, output mem_rdata, mem_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads instruction memory at the incoming PC and holds the result for decode.
//
// state  | meaning
// LOAD   | latch pc into req_addr unless a held instruction is stalled
// REQ    | read request outstanding, counting wait states
// ERR    | memory timeout, sticky until reset
module fetch_unit #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      mem,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              pc_en_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    output logic              fetch_err_o
);
    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        wait_cnt_d = wait_cnt_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        case (state_q)
            S_LOAD: begin
                if (flush_i) begin
                    valid_d = 1'b0;
                end else if (!(valid_q && stall_i)) begin
                    // Leaving LOAD also consumes any held instruction decode accepted this cycle.
                    valid_d    = 1'b0;
                    req_addr_d = pc_i;
                    wait_cnt_d = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    valid_d = 1'b0;
                    state_d = S_LOAD;
                end else if (mem.mem_ready) begin
                    instr_d    = mem.mem_rdata;
                    instr_pc_d = req_addr_q;
                    valid_d    = 1'b1;
                    state_d    = S_LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            req_addr_q <= '0;
            wait_cnt_q <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            wait_cnt_q <= wait_cnt_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign mem.mem_addr  = req_addr_q;
    assign mem.mem_ren   = (state_q == S_REQ);
    assign pc_en_o       = (state_q == S_REQ) && mem.mem_ready && !flush_i;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign fetch_err_o   = (state_q == S_ERR);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC updater and instruction memory models around the DUT.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        auto_rdy = 1'b0;
    logic        man_ready = 1'b0;
    logic [15:0] flush_target = 16'h0040;
    logic        pc_en;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        fetch_err;
    logic [15:0] mem [0:65535];
    int          n_checks = 0;
    int          n_fail = 0;

    fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) mem_bus ();

    fetch_unit #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem           (mem_bus.master),
        .pc_i          (pc),
        .stall_i       (stall),
        .flush_i       (flush),
        .pc_en_o       (pc_en),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .fetch_err_o   (fetch_err)
    );

    always #5 clk = ~clk;

    assign mem_bus.mem_rdata = mem[mem_bus.mem_addr];
    assign mem_bus.mem_ready = auto_rdy ? mem_bus.mem_ren : man_ready;

    // PC updater: reset to 0, load branch target on flush, advance by 2 on pc_en.
    always @(posedge clk) begin
        if (rst) pc <= 16'h0000;
        else if (flush) pc <= flush_target;
        else if (pc_en) pc <= pc + 16'd2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges; returns just after the release edge (LOAD cycle, pc=0).
    task automatic apply_reset();
        step();
        rst = 1'b1;
        flush = 1'b0;
        stall = 1'b0;
        auto_rdy = 1'b0;
        man_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        n_checks++;
        if ({mem_bus.mem_ren, pc_en, instr_valid, fetch_err, mem_bus.mem_addr, instr, instr_pc} !== 52'h0) begin
            n_fail++;
            $display("FAIL reset_edge1: ren/pcen/valid/err=%b%b%b%b addr=%h instr=%h ipc=%h, required all 0",
                     mem_bus.mem_ren, pc_en, instr_valid, fetch_err, mem_bus.mem_addr, instr, instr_pc);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_bus.mem_ren, pc_en, instr_valid, fetch_err, mem_bus.mem_addr, instr, instr_pc} !== 52'h0) begin
            n_fail++;
            $display("FAIL reset_release: ren/pcen/valid/err=%b%b%b%b addr=%h instr=%h ipc=%h, required all 0",
                     mem_bus.mem_ren, pc_en, instr_valid, fetch_err, mem_bus.mem_addr, instr, instr_pc);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({mem_bus.mem_ren, mem_bus.mem_addr} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_first_req: ren=%b addr=%h, required ren=1 addr=0000", mem_bus.mem_ren, mem_bus.mem_addr);
        end
    endtask

    task automatic test_streaming();
        logic [15:0] exp_instr [0:2];
        int          pulses;
        exp_instr[0] = 16'h1111;
        exp_instr[1] = 16'h2222;
        exp_instr[2] = 16'h3333;
        pulses = 0;
        apply_reset();
        auto_rdy = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (pc_en === 1'b1) pulses++;
            n_checks++;
            if ({instr_valid, pc_en, mem_bus.mem_ren} !== {(c > 0 && c % 2 == 0), c[0], c[0]}) begin
                n_fail++;
                $display("FAIL stream_ctrl c%0d: valid/pcen/ren=%b%b%b, required %b%b%b", c, instr_valid, pc_en,
                         mem_bus.mem_ren, (c > 0 && c % 2 == 0), c[0], c[0]);
            end
            if (c > 0 && c % 2 == 0) begin
                n_checks++;
                if ({instr_pc, instr} !== {16'((c / 2 - 1) * 2), exp_instr[c / 2 - 1]}) begin
                    n_fail++;
                    $display("FAIL stream_data c%0d: pc=%h instr=%h, required pc=%h instr=%h", c, instr_pc, instr,
                             16'((c / 2 - 1) * 2), exp_instr[c / 2 - 1]);
                end
            end
            step();
        end
        n_checks++;
        if (pulses !== 3) begin
            n_fail++;
            $display("FAIL stream_pc_en_count: got %0d pulses, required 3", pulses);
        end
    endtask

    task automatic test_wait_states();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (mem_bus.mem_ren !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_load: ren=%b, required 0", mem_bus.mem_ren);
        end
        for (int c = 1; c <= 4; c++) begin
            step();
            man_ready = (c == 4);
            @(negedge clk);
            n_checks++;
            if ({mem_bus.mem_ren, pc_en, fetch_err, mem_bus.mem_addr} !== {1'b1, (c == 4), 1'b0, 16'h0000}) begin
                n_fail++;
                $display("FAIL wait_req c%0d: ren/pcen/err=%b%b%b addr=%h, required %b%b0 addr=0000", c,
                         mem_bus.mem_ren, pc_en, fetch_err, mem_bus.mem_addr, 1'b1, (c == 4));
            end
        end
        step();
        man_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_bus.mem_ren, fetch_err, instr_valid, instr_pc, instr} !== {3'b001, 16'h0000, 16'h1111}) begin
            n_fail++;
            $display("FAIL wait_capture: ren/err/valid=%b%b%b pc=%h instr=%h, required 001 pc=0000 instr=1111",
                     mem_bus.mem_ren, fetch_err, instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        auto_rdy = 1'b1;
        repeat (4) step();
        for (int k = 0; k < 5; k++) begin
            stall = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({instr_valid, mem_bus.mem_ren, pc_en, instr_pc, instr} !== {3'b100, 16'h0002, 16'h2222}) begin
                n_fail++;
                $display("FAIL stall_hold k%0d: valid/ren/pcen=%b%b%b pc=%h instr=%h, required 100 pc=0002 instr=2222",
                         k, instr_valid, mem_bus.mem_ren, pc_en, instr_pc, instr);
            end
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({instr_valid, mem_bus.mem_ren} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_release: valid/ren=%b%b, required 10", instr_valid, mem_bus.mem_ren);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({instr_valid, mem_bus.mem_ren, mem_bus.mem_addr, instr} !== {2'b01, 16'h0004, 16'h2222}) begin
            n_fail++;
            $display("FAIL stall_next_req: valid/ren=%b%b addr=%h instr=%h, required 01 addr=0004 instr=2222",
                     instr_valid, mem_bus.mem_ren, mem_bus.mem_addr, instr);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        auto_rdy = 1'b1;
        step();
        flush = 1'b1;
        flush_target = 16'h0040;
        @(negedge clk);
        n_checks++;
        if ({mem_bus.mem_ren, pc_en, instr_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL flush_req: ren/pcen/valid=%b%b%b, required 100", mem_bus.mem_ren, pc_en, instr_valid);
        end
        step();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_bus.mem_ren, instr_valid, instr} !== {2'b00, 16'h0000}) begin
            n_fail++;
            $display("FAIL flush_no_capture: ren/valid=%b%b instr=%h, required 00 instr=0000", mem_bus.mem_ren,
                     instr_valid, instr);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({mem_bus.mem_ren, mem_bus.mem_addr} !== {1'b1, 16'h0040}) begin
            n_fail++;
            $display("FAIL flush_target_req: ren=%b addr=%h, required ren=1 addr=0040", mem_bus.mem_ren,
                     mem_bus.mem_addr);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0040, 16'h5555}) begin
            n_fail++;
            $display("FAIL flush_target_data: valid=%b pc=%h instr=%h, required 1 0040 5555", instr_valid, instr_pc,
                     instr);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        flush_target = 16'h0020;
        for (int c = 1; c <= 4; c++) begin
            step();
            @(negedge clk);
            n_checks++;
            if ({mem_bus.mem_ren, fetch_err} !== 2'b10) begin
                n_fail++;
                $display("FAIL timeout_wait c%0d: ren/err=%b%b, required 10", c, mem_bus.mem_ren, fetch_err);
            end
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({fetch_err, mem_bus.mem_ren, pc_en, instr_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL timeout_err: err/ren/pcen/valid=%b%b%b%b, required 1000", fetch_err, mem_bus.mem_ren,
                     pc_en, instr_valid);
        end
        step();
        flush = 1'b1;
        man_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fetch_err, mem_bus.mem_ren, pc_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL timeout_flush_cycle: err/ren/pcen=%b%b%b, required 100", fetch_err, mem_bus.mem_ren, pc_en);
        end
        step();
        flush = 1'b0;
        man_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fetch_err, mem_bus.mem_ren} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_sticky: err/ren=%b%b, required 10", fetch_err, mem_bus.mem_ren);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({fetch_err, mem_bus.mem_ren, pc_en, instr_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_rst_clear: err/ren/pcen/valid=%b%b%b%b, required 0000", fetch_err,
                     mem_bus.mem_ren, pc_en, instr_valid);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({mem_bus.mem_ren, mem_bus.mem_addr} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL timeout_restart: ren=%b addr=%h, required ren=1 addr=0000", mem_bus.mem_ren,
                     mem_bus.mem_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'hA000 ^ 16'(i);
        mem[16'h0000] = 16'h1111;
        mem[16'h0002] = 16'h2222;
        mem[16'h0004] = 16'h3333;
        mem[16'h0040] = 16'h5555;
        test_reset();
        test_streaming();
        test_wait_states();
        test_stall();
        test_flush();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage, directly downstream of the PC updater.
- Takes the current PC, issues a read to instruction memory, and waits out memory wait states.
- Holds the fetched instruction and its PC in an output slot for decode, which can stall it.
- Pulses pc_en to advance the PC; supports flush on branch redirect; raises a sticky error on memory timeout.

Parameters:
ADDR_W, 16, width of PC and memory address
DATA_W, 16, instruction width
MAX_WAIT, 15, max cycles in REQ without mem_ready before error (>=1)
CNT_W, 4, wait counter width; must hold MAX_WAIT

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
pc  in  ADDR_W  current PC from PC updater
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
mem_ready  in  1  memory response for current request
stall  in  1  decode cannot accept instr this cycle
flush  in  1  branch redirect; kill in-flight/held instruction
mem_addr  out  ADDR_W  request address (registered req_addr)
mem_ren  out  1  read request, high exactly in REQ state
pc_en  out  1  combinational; PC updater advances PC at this edge
instr  out  DATA_W  held instruction
instr_pc  out  ADDR_W  address of held instruction
instr_valid  out  1  output slot occupied
fetch_err  out  1  sticky memory-timeout flag

Behaviour:
- Priority: rst > flush > all else.
- Reset values:
  - state LOAD
  - mem_addr=0, mem_ren=0, pc_en=0
  - instr=0, instr_pc=0, instr_valid=0
  - fetch_err=0, wait_cnt=0
- States: LOAD, REQ, ERR.
- LOAD:
  - mem_ren=0.
  - At edge: if !(instr_valid && stall), req_addr<=pc, wait_cnt<=0, go REQ. Otherwise stay in LOAD.
- REQ:
  - mem_ren=1; mem_addr=req_addr, stable for the whole request.
  - instr_valid is always 0 on entry.
  - mem_ready=1 and no flush: pc_en=1 this cycle. At edge: instr<=mem_rdata, instr_pc<=req_addr, instr_valid<=1, go LOAD.
  - mem_ready=0: wait_cnt++. If wait_cnt==MAX_WAIT-1 at the edge, go ERR.
- ERR:
  - mem_ren=0, pc_en=0, instr_valid=0, fetch_err=1.
  - Held until rst.
  - flush ignored.
- Consumption: at an edge with instr_valid && !stall && no new capture, instr_valid<=0. instr and instr_pc keep their old value.
- Throughput: minimum 2 cycles per instruction (LOAD+REQ) with zero-wait memory.
- pc_en is asserted only in a REQ cycle with mem_ready=1 and flush=0. It is never asserted in LOAD or ERR.
- flush=1 at an edge (not ERR):
  - instr_valid<=0, go LOAD.
  - In REQ, the request is abandoned: no capture, even if mem_ready=1; pc_en=0.
  - The PC updater loads the branch target at the same edge, so the next LOAD latches the target.
- mem_ready while mem_ren=0 is ignored.
- stall with instr_valid=0 has no effect.
- rst mid-request: next cycle all reset values. The memory must tolerate the abandoned request.
- req_addr is not incremented internally; the PC always comes from the pc input.

Test Plan:
1. Reset: rst=1 for 2 edges.
   - During reset: all outputs 0.
   - First cycle after release: mem_ren=0.
   - Next cycle: mem_ren=1, mem_addr=0x0000.
2. Zero-wait streaming: mem_ready=mem_ren, mem[0]=0x1111, mem[2]=0x2222, mem[4]=0x3333, stall=0, pc model increments by 2 on pc_en.
   - instr_valid high every other cycle with (instr_pc,instr) = (0,0x1111), (2,0x2222), (4,0x3333).
   - One pc_en pulse per instruction.
3. Wait states: mem_ready high on the 4th REQ cycle.
   - mem_ren high for exactly 4 cycles with mem_addr constant.
   - pc_en only in the 4th cycle.
   - fetch_err=0.
4. Stall: instruction 0x2222 valid, stall=1 for 5 cycles.
   - instr and instr_pc hold; instr_valid stays 1; mem_ren=0; pc_en=0.
   - After stall drops: consumed, and the next cycle is REQ at the next PC.
5. Flush: flush=1 in a REQ cycle with mem_ready=1, while the PC model loads 0x0040.
   - No capture; pc_en=0; instr_valid=0.
   - Next cycle: LOAD, then REQ with mem_addr=0x0040.
6. Timeout: MAX_WAIT=4, mem_ready stuck at 0.
   - After 4 REQ cycles: fetch_err=1, mem_ren=0.
   - flush does not clear it; rst=1 clears fetch_err and fetch restarts at pc.
